// File: rtl/wt_dcache_rd_ctrl_pkg.sv
// Shared types and geometry for the write-through dcache read-port controller.
package wt_cache_pkg;

    localparam int CL_IDX_W         = 8;
    localparam int OFFSET_W         = 4;
    localparam int DCACHE_TAG_WIDTH = 20;
    localparam int SET_ASSOC        = 4;
    localparam int CACHE_ID_WIDTH   = 2;
    localparam int PADDR_W          = 64;
    localparam int PADDR_PAD        = PADDR_W - DCACHE_TAG_WIDTH - CL_IDX_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_TAG,
        MISS_REQ,
        MISS_WAIT,
        REPLAY_REQ,
        REPLAY_READ,
        KILL_MISS
    } rd_ctrl_state_e;

    typedef struct packed {
        logic                      nc;
        logic [2:0]                size;
        logic [PADDR_W-1:0]        paddr;
        logic [SET_ASSOC-1:0]      vld_bits;
        logic [CACHE_ID_WIDTH-1:0] id;
    } miss_req_t;

    // Physical address of a load, zero-extended to the full bus width.
    function automatic logic [PADDR_W-1:0] build_paddr(
        input logic [DCACHE_TAG_WIDTH-1:0] tag,
        input logic [CL_IDX_W-1:0]         idx,
        input logic [OFFSET_W-1:0]         off
    );
        return {{PADDR_PAD{1'b0}}, tag, idx, off};
    endfunction

endpackage

// File: rtl/wt_dcache_rd_ctrl_if.sv
// Memory read port plus miss-unit handshake seen by one read-port controller.
interface wt_dcache_rd_ctrl_if;
    import wt_cache_pkg::*;

    // memory read port
    logic                        rd_req;
    logic                        rd_ack;
    logic [CL_IDX_W-1:0]         rd_idx;
    logic [OFFSET_W-1:0]         rd_off;
    logic [DCACHE_TAG_WIDTH-1:0] rd_tag;
    logic                        rd_tag_only;
    logic                        rd_prio;
    logic [SET_ASSOC-1:0]        rd_vld_bits;
    logic [SET_ASSOC-1:0]        rd_hit_oh;
    logic [63:0]                 rd_data;
    logic                        wr_cl_vld;

    // miss unit
    logic                        miss_req;
    logic                        miss_ack;
    logic                        miss_nc;
    logic [2:0]                  miss_size;
    logic [PADDR_W-1:0]          miss_paddr;
    logic [SET_ASSOC-1:0]        miss_vld_bits;
    logic [CACHE_ID_WIDTH-1:0]   miss_id;
    logic                        miss_replay;
    logic                        miss_rtrn_vld;

    modport master (
        output rd_req, rd_idx, rd_off, rd_tag, rd_tag_only, rd_prio,
        input  rd_ack, rd_vld_bits, rd_hit_oh, rd_data, wr_cl_vld,
        output miss_req, miss_nc, miss_size, miss_paddr, miss_vld_bits, miss_id,
        input  miss_ack, miss_replay, miss_rtrn_vld
    );

    modport slave (
        input  rd_req, rd_idx, rd_off, rd_tag, rd_tag_only, rd_prio,
        output rd_ack, rd_vld_bits, rd_hit_oh, rd_data, wr_cl_vld,
        input  miss_req, miss_nc, miss_size, miss_paddr, miss_vld_bits, miss_id,
        output miss_ack, miss_replay, miss_rtrn_vld
    );

endinterface

// File: rtl/wt_dcache_rd_ctrl.sv
// Read-port initiator: one outstanding LSU load, hit check, miss request and replay.
module wt_dcache_rd_ctrl
    import wt_cache_pkg::*;
#(
    parameter logic [CACHE_ID_WIDTH-1:0] RdTxId = 1,
    parameter logic                      RdPrio = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // LSU side
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [CL_IDX_W-1:0]         idx_i,
    input  logic [OFFSET_W-1:0]         off_i,
    input  logic [1:0]                  size_i,
    input  logic                        tag_valid_i,
    input  logic [DCACHE_TAG_WIDTH-1:0] tag_i,
    input  logic                        nc_i,
    input  logic                        kill_i,
    output logic                        rvalid_o,
    output logic [63:0]                 rdata_o,
    // memory and miss unit
    wt_dcache_rd_ctrl_if.master         mem_if
);

    rd_ctrl_state_e              state_q, state_d;
    logic [CL_IDX_W-1:0]         idx_q, idx_d;
    logic [OFFSET_W-1:0]         off_q, off_d;
    logic [1:0]                  size_q, size_d;
    logic [DCACHE_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                        nc_q, nc_d;
    logic [SET_ASSOC-1:0]        vld_q, vld_d;

    logic                        rd_req;
    logic [CL_IDX_W-1:0]         rd_idx;
    logic [OFFSET_W-1:0]         rd_off;
    logic [DCACHE_TAG_WIDTH-1:0] rd_tag;
    logic                        miss_req;
    logic                        cur_nc;
    miss_req_t                   miss_info;

    // State and request/tag capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            tag_q   <= '0;
            nc_q    <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            tag_q   <= tag_d;
            nc_q    <= nc_d;
            vld_q   <= vld_d;
        end
    end

    // Next state and all handshake outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        off_d    = off_q;
        size_d   = size_q;
        tag_d    = tag_q;
        nc_d     = nc_q;
        vld_d    = vld_q;
        gnt_o    = 1'b0;
        rvalid_o = 1'b0;
        rdata_o  = '0;
        rd_req   = 1'b0;
        rd_idx   = idx_q;
        rd_off   = off_q;
        rd_tag   = tag_q;
        miss_req = 1'b0;
        cur_nc   = nc_q;

        unique case (state_q)
            IDLE: begin
                rd_req = req_i;
                rd_idx = idx_i;
                rd_off = off_i;
                gnt_o  = req_i & mem_if.rd_ack;
                if (gnt_o) begin
                    idx_d   = idx_i;
                    off_d   = off_i;
                    size_d  = size_i;
                    state_d = READ;
                end
            end

            // First read uses the live tag; a replay uses the captured one.
            READ, REPLAY_READ: begin
                if (state_q == READ) begin
                    rd_tag = tag_i;
                    cur_nc = nc_i;
                    if (tag_valid_i) begin
                        tag_d = tag_i;
                        nc_d  = nc_i;
                    end
                end
                if (kill_i) begin
                    state_d = IDLE;
                end else if (state_q == READ && !tag_valid_i) begin
                    state_d = WAIT_TAG;
                end else if (mem_if.wr_cl_vld) begin
                    // readout collided with a line write and cannot be trusted
                    state_d = REPLAY_REQ;
                end else if (cur_nc || (mem_if.rd_hit_oh == '0)) begin
                    vld_d   = mem_if.rd_vld_bits;
                    state_d = MISS_REQ;
                end else begin
                    rvalid_o = 1'b1;
                    rdata_o  = mem_if.rd_data;
                    // a held request can be taken in the same cycle as the hit
                    rd_req   = req_i;
                    rd_idx   = idx_i;
                    rd_off   = off_i;
                    gnt_o    = req_i & mem_if.rd_ack;
                    if (gnt_o) begin
                        idx_d   = idx_i;
                        off_d   = off_i;
                        size_d  = size_i;
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            WAIT_TAG: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (tag_valid_i) begin
                    tag_d   = tag_i;
                    nc_d    = nc_i;
                    state_d = REPLAY_REQ;
                end
            end

            REPLAY_REQ: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    rd_req = 1'b1;
                    if (mem_if.rd_ack) begin
                        state_d = REPLAY_READ;
                    end
                end
            end

            MISS_REQ: begin
                miss_req = 1'b1;
                if (mem_if.miss_ack) begin
                    // once accepted, a kill must still wait for the miss to drain
                    state_d = kill_i ? KILL_MISS : MISS_WAIT;
                end else if (kill_i) begin
                    state_d = IDLE;
                end
            end

            MISS_WAIT: begin
                if (mem_if.miss_replay) begin
                    state_d = kill_i ? IDLE : REPLAY_REQ;
                end else if (mem_if.miss_rtrn_vld) begin
                    if (kill_i) begin
                        state_d = IDLE;
                    end else if (nc_q) begin
                        rvalid_o = 1'b1;
                        rdata_o  = mem_if.rd_data;
                        state_d  = IDLE;
                    end else begin
                        state_d = REPLAY_REQ;
                    end
                end else if (kill_i) begin
                    state_d = KILL_MISS;
                end
            end

            KILL_MISS: begin
                if (mem_if.miss_rtrn_vld || mem_if.miss_replay) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign miss_info = '{
        nc:       nc_q,
        size:     {1'b0, size_q},
        paddr:    build_paddr(tag_q, idx_q, off_q),
        vld_bits: vld_q,
        id:       RdTxId
    };

    assign mem_if.rd_req        = rd_req;
    assign mem_if.rd_idx        = rd_idx;
    assign mem_if.rd_off        = rd_off;
    assign mem_if.rd_tag        = rd_tag;
    assign mem_if.rd_tag_only   = 1'b0;
    assign mem_if.rd_prio       = RdPrio;
    assign mem_if.miss_req      = miss_req;
    assign mem_if.miss_nc       = miss_info.nc;
    assign mem_if.miss_size     = miss_info.size;
    assign mem_if.miss_paddr    = miss_info.paddr;
    assign mem_if.miss_vld_bits = miss_info.vld_bits;
    assign mem_if.miss_id       = miss_info.id;

endmodule
